// File: rtl/gradient_pkg.sv
// Shared definitions for the gradient magnitude pipeline: norm-select
// constants and the input-to-output latency as a function of data width.
package gradient_pkg;

  localparam logic MODE_L2 = 1'b0;
  localparam logic MODE_L1 = 1'b1;

  // Abs stage + square stage + sum stage + one stage per root bit.
  function automatic int grad_lat(input int data_width);
    return data_width + 3;
  endfunction

endpackage

// File: rtl/gradient_mag_isqrt_pipe.sv
// Bit-serial pipelined integer square root, one result bit per stage, MSB
// first (restoring digit recurrence). The last bit is resolved
// combinationally so the caller can register it together with its own output
// mux; every earlier stage is registered. Latency is IN_WIDTH/2 - 1 enabled
// cycles to the combinational outputs. Valid and a user sideband ride along
// unmodified.
module isqrt_pipe
  import gradient_pkg::*;
#(
  parameter int IN_WIDTH   = 24,
  parameter int USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    valid_i,
  input  logic [IN_WIDTH-1:0]     rad_i,
  input  logic [USER_WIDTH-1:0]   user_i,
  output logic                    valid_o,
  output logic [IN_WIDTH/2-1:0]   root_o,
  output logic [USER_WIDTH-1:0]   user_o
);

  localparam int OW = IN_WIDTH / 2;
  localparam int RW = OW + 2;

  // Trial subtraction succeeds: the next root bit is 1.
  function automatic logic fits(input logic [RW-1:0] rem, input logic [OW-1:0] root,
                                input logic [1:0] pair);
    logic [RW+1:0] sh;
    logic [RW+1:0] tr;
    sh = {rem, pair};
    tr = {2'b00, root, 2'b01};
    return (sh >= tr);
  endfunction

  // Partial remainder after bringing down the next two radicand bits.
  function automatic logic [RW-1:0] next_rem(input logic [RW-1:0] rem, input logic [OW-1:0] root,
                                             input logic [1:0] pair);
    logic [RW+1:0] sh;
    logic [RW+1:0] tr;
    logic [RW+1:0] df;
    sh = {rem, pair};
    tr = {2'b00, root, 2'b01};
    df = (sh >= tr) ? (sh - tr) : sh;
    return df[RW-1:0];
  endfunction

  for (genvar s = 0; s < OW; s++) begin : g_stage
    localparam int B = 2 * (OW - 1 - s);

    logic [RW-1:0]         rem_in;
    logic [OW-1:0]         root_in;
    logic [IN_WIDTH-1:0]   rad_in;
    logic                  vld_in;
    logic [USER_WIDTH-1:0] user_in;
    logic [1:0]            pair;
    logic [OW-1:0]         root_nx;

    if (s == 0) begin : g_head
      assign rem_in  = '0;
      assign root_in = '0;
      assign rad_in  = rad_i;
      assign vld_in  = valid_i;
      assign user_in = user_i;
    end else begin : g_body
      assign rem_in  = g_stage[s-1].g_reg.rem_q;
      assign root_in = g_stage[s-1].g_reg.root_q;
      assign rad_in  = g_stage[s-1].g_reg.rad_q;
      assign vld_in  = g_stage[s-1].g_reg.vld_q;
      assign user_in = g_stage[s-1].g_reg.user_q;
    end

    assign pair    = rad_in[B+1:B];
    assign root_nx = {root_in[OW-2:0], fits(rem_in, root_in, pair)};

    if (s < OW - 1) begin : g_reg
      logic [RW-1:0]         rem_q;
      logic [OW-1:0]         root_q;
      logic [IN_WIDTH-1:0]   rad_q;
      logic                  vld_q;
      logic [USER_WIDTH-1:0] user_q;

      // Valid bit of this root stage: cleared by reset, held when ce is low.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     vld_q <= 1'b0;
        else if (ce) vld_q <= vld_in;
      end

      // Root stage datapath: resolve one root bit and advance the remainder.
      always_ff @(posedge clk) begin
        if (ce) begin
          rem_q  <= next_rem(rem_in, root_in, pair);
          root_q <= root_nx;
          rad_q  <= rad_in;
          user_q <= user_in;
        end
      end
    end else begin : g_tail
      assign valid_o = vld_in;
      assign root_o  = root_nx;
      assign user_o  = user_in;
    end
  end

endmodule

// File: rtl/gradient_mag.sv
// Gradient magnitude: per pixel, L2 = floor(sqrt(Gx^2+Gy^2)) or
// L1 = min(|Gx|+|Gy|, 2^DATA_WIDTH-1), selected per pixel by in_mode.
// Fixed latency DATA_WIDTH+3 enabled cycles for both modes; ce freezes all.
// Optional macro GRADIENT_MAG_THRESH_EN adds thresh input and out_edge output.
module gradient_mag
  import gradient_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int USER_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] Gx,
  input  logic [DATA_WIDTH-1:0] Gy,
  input  logic                  in_mode,
  input  logic [USER_WIDTH-1:0] in_user,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [USER_WIDTH-1:0] out_user
`ifdef GRADIENT_MAG_THRESH_EN
  ,
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic                  out_edge
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH;
  localparam int CW = 1 + DATA_WIDTH + USER_WIDTH;  // {mode, l1, user}

  // |v| as unsigned; the most negative code maps to 2^(DW-1) without wrap.
  function automatic logic [DW-1:0] abs_val(input logic signed [DW-1:0] v);
    return v[DW-1] ? DW'(~v + 1'b1) : v;
  endfunction

  function automatic logic [DW-1:0] sat_l1(input logic [DW:0] s);
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  logic signed [DW-1:0] gx_s;
  logic signed [DW-1:0] gy_s;
  assign gx_s = Gx;
  assign gy_s = Gy;

  logic [DW-1:0]         absx_p1, absy_p1;
  logic                  mode_p1, vld_p1;
  logic [USER_WIDTH-1:0] user_p1;
  logic [SW-1:0]         sqx_p2, sqy_p2;
  logic [DW:0]           l1_p2;
  logic                  mode_p2, vld_p2;
  logic [USER_WIDTH-1:0] user_p2;
  logic [SW-1:0]         sum_p3;
  logic [DW-1:0]         l1sat_p3;
  logic                  mode_p3, vld_p3;
  logic [USER_WIDTH-1:0] user_p3;

  // Valid bits of the three front stages: cleared by reset, held when ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (ce) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Front datapath: abs values, then squares and L1 sum, then sum of squares.
  always_ff @(posedge clk) begin
    if (ce) begin
      // stage 1: magnitudes
      absx_p1  <= abs_val(gx_s);
      absy_p1  <= abs_val(gy_s);
      mode_p1  <= in_mode;
      user_p1  <= in_user;
      // stage 2: squares and L1 sum in parallel
      sqx_p2   <= SW'(absx_p1) * SW'(absx_p1);
      sqy_p2   <= SW'(absy_p1) * SW'(absy_p1);
      l1_p2    <= {1'b0, absx_p1} + {1'b0, absy_p1};
      mode_p2  <= mode_p1;
      user_p2  <= user_p1;
      // stage 3: sum of squares, L1 saturated
      sum_p3   <= sqx_p2 + sqy_p2;
      l1sat_p3 <= sat_l1(l1_p2);
      mode_p3  <= mode_p2;
      user_p3  <= user_p2;
    end
  end

  logic                  sq_vld;
  logic [DW-1:0]         sq_root;
  logic [CW-1:0]         sq_side;

  // The L1 result and mode ride the root pipe's sideband as the delay path.
  isqrt_pipe #(
    .IN_WIDTH   (SW),
    .USER_WIDTH (CW)
  ) u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .valid_i (vld_p3),
    .rad_i   (sum_p3),
    .user_i  ({mode_p3, l1sat_p3, user_p3}),
    .valid_o (sq_vld),
    .root_o  (sq_root),
    .user_o  (sq_side)
  );

  logic [DW-1:0]         mag;
  logic [DW-1:0]         out_data_d, out_data_q;
  logic [USER_WIDTH-1:0] out_user_d, out_user_q;
  logic                  out_valid_q;
  logic                  edge_d;

  // Output mux by carried mode; bubbles are forced to zero for determinism.
  always_comb begin
    mag        = sq_root;
    out_data_d = '0;
    out_user_d = '0;
    edge_d     = 1'b0;
    if (sq_side[CW-1] == MODE_L1) mag = sq_side[CW-2 -: DW];
    if (sq_vld) begin
      out_data_d = mag;
      out_user_d = sq_side[USER_WIDTH-1:0];
`ifdef GRADIENT_MAG_THRESH_EN
      edge_d     = (mag >= thresh);
`endif
    end
  end

`ifdef GRADIENT_MAG_THRESH_EN
  logic edge_q;
`endif

  // Output registers: cleared by reset, held when ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
`ifdef GRADIENT_MAG_THRESH_EN
      edge_q      <= 1'b0;
`endif
    end else if (ce) begin
      out_valid_q <= sq_vld;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
`ifdef GRADIENT_MAG_THRESH_EN
      edge_q      <= edge_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_user  = out_user_q;
`ifdef GRADIENT_MAG_THRESH_EN
  assign out_edge  = edge_q;
`else
  logic unused_edge;
  assign unused_edge = edge_d;
`endif

endmodule

// File: tb/tb_gradient_mag.sv
// Self-checking bench for gradient_mag: directed spec values, random
// back-to-back traffic, ce freezes and mid-stream reset, against a
// reference model of expected outputs per enabled cycle.
module tb_gradient_mag;
  import gradient_pkg::*;

  localparam int DW  = 12;
  localparam int UW  = 2;
  localparam int LAT = grad_lat(DW);

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          in_valid;
  logic [DW-1:0] Gx, Gy;
  logic          in_mode;
  logic [UW-1:0] in_user;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [UW-1:0] out_user;
  logic [DW-1:0] thresh;
  logic          out_edge;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic          e;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  always #5 clk = ~clk;

  gradient_mag #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .Gx        (Gx),
    .Gy        (Gy),
    .in_mode   (in_mode),
    .in_user   (in_user),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_user  (out_user)
`ifdef GRADIENT_MAG_THRESH_EN
    ,
    .thresh    (thresh),
    .out_edge  (out_edge)
`endif
  );

`ifndef GRADIENT_MAG_THRESH_EN
  assign out_edge = 1'b0;
`endif

  function automatic longint isqrt_ref(input longint s);
    longint r;
    r = longint'($sqrt(real'(s)));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  // Expected output for one pixel, straight from the norm definitions.
  function automatic exp_t model(input logic v, input logic [DW-1:0] gx, input logic [DW-1:0] gy,
                                 input logic m, input logic [UW-1:0] u, input logic [DW-1:0] th);
    exp_t   e;
    longint x, y, mg;
    x  = longint'($signed(gx));
    y  = longint'($signed(gy));
    x  = (x < 0) ? -x : x;
    y  = (y < 0) ? -y : y;
    if (m) mg = (x + y > (2**DW) - 1) ? (2**DW) - 1 : x + y;
    else   mg = isqrt_ref(x * x + y * y);
    e.v = v;
    e.d = DW'(mg);
    e.u = u;
    e.e = v && (mg >= longint'(th));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    repeat (LAT - 1) q.push_back('0);
    cur = '0;
  endtask

  // One clock: drive, advance model on enabled edges, sample 1 time unit later.
  task automatic step(input logic v, input logic [DW-1:0] gx, input logic [DW-1:0] gy,
                      input logic m, input logic [UW-1:0] u, input logic c);
    in_valid = v; Gx = gx; Gy = gy; in_mode = m; in_user = u; ce = c;
    @(posedge clk);
    if (c && !rst) begin
      q.push_back(model(v, gx, gy, m, u, thresh));
      cur = q.pop_front();
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(cur.v));
    if (cur.v) begin
      chk("out_data", 64'(out_data), 64'(cur.d));
      chk("out_user", 64'(out_user), 64'(cur.u));
`ifdef GRADIENT_MAG_THRESH_EN
      chk("out_edge", 64'(out_edge), 64'(cur.e));
`endif
    end
  endtask

  task automatic bubbles(input int n);
    repeat (n) step(1'b0, DW'($urandom), DW'($urandom), 1'($urandom), UW'($urandom), 1'b1);
  endtask

  // Lone pixel followed by bubbles; literal result checked at exactly LAT cycles.
  task automatic directed(input string tag, input int gx, input int gy, input logic m,
                          input int expd, input logic expe);
    step(1'b1, DW'(gx), DW'(gy), m, 2'b10, 1'b1);
    bubbles(LAT - 1);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk(tag, 64'(out_data), 64'(expd));
    chk({tag, "_user"}, 64'(out_user), 64'd2);
`ifdef GRADIENT_MAG_THRESH_EN
    chk({tag, "_edge"}, 64'(out_edge), 64'(expe));
`else
    if (expe) tests = tests + 0;
`endif
  endtask

  initial begin
    thresh = DW'(5);
    in_valid = 1'b0; Gx = '0; Gy = '0; in_mode = 1'b0; in_user = '0; ce = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_user",  64'(out_user),  64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    directed("l2_3_4",       3,     4,     MODE_L2, 5,    1'b1);
    directed("l2_m2048",     -2048, -2048, MODE_L2, 2896, 1'b1);
    directed("l1_m2048_sat", -2048, -2048, MODE_L1, 4095, 1'b1);
    directed("l1_100_m27",   100,   -27,   MODE_L1, 127,  1'b1);
    directed("l2_3_3",       3,     3,     MODE_L2, 4,    1'b0);
    directed("l1_zero",      0,     0,     MODE_L1, 0,    1'b0);

    // Back-to-back random pixels, alternating mode.
    for (int i = 0; i < 1000; i++)
      step(1'b1, DW'($urandom), DW'($urandom), 1'(i), UW'($urandom), 1'b1);
    bubbles(LAT);

    // Four pixels in flight, then ce low for five cycles.
    for (int i = 0; i < 4; i++)
      step(1'b1, DW'($urandom), DW'($urandom), 1'(i), UW'($urandom), 1'b1);
    repeat (5) step(1'b1, DW'($urandom), DW'($urandom), 1'($urandom), UW'($urandom), 1'b0);
    bubbles(LAT - 4);
    chk("ce_first_out", 64'(out_valid), 64'd1);
    bubbles(4);

    // Random ce toggling with random valids, including freezes while outputs are valid.
    for (int i = 0; i < 300; i++)
      step(1'($urandom), DW'($urandom), DW'($urandom), 1'($urandom), UW'($urandom), 1'($urandom));
    bubbles(LAT);

    // Reset while pixels are in flight and being output.
    for (int i = 0; i < 20; i++)
      step(1'b1, DW'($urandom), DW'($urandom), 1'(i), UW'($urandom), 1'b1);
    rst = 1'b1;
    #2;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data",  64'(out_data),  64'd0);
    chk("midrst_user",  64'(out_user),  64'd0);
    in_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("midrst_hold", 64'(out_valid), 64'd0);
    rst = 1'b0;
    model_reset();
    directed("post_rst", 3, 4, MODE_L2, 5, 1'b1);
    bubbles(LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
